// File: rtl/arb_pkg.sv
// Shared types, constants and helpers for the round-robin request arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT,
    LCK
  } arb_state_t;

  localparam logic [23:0] DIR_LSB = "LSB";
  localparam logic [23:0] DIR_MSB = "MSB";

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  localparam int IMPL_LOOP   = 0;
  localparam int IMPL_VECTOR = 1;
  localparam int IMPL_ADDER  = 2;

  // Sized for the widest supported requester count; callers truncate.
  function automatic logic [5:0] onehot2bin(input logic [63:0] oht);
    logic [5:0] bin;
    bin = '0;
    for (int i = 0; i < 64; i++) begin
      if (oht[i]) bin = bin | 6'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/pry2oht_msk.sv
// Combinational masked priority-to-one-hot: oht = first set bit of (req & msk)
// in DIRECTION order; zero latency, no flow control.
module pry2oht_msk
  import arb_pkg::*;
#(
  parameter int          WIDTH          = 4,
  parameter logic [23:0] DIRECTION      = "LSB",
  parameter int          IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] msk,
  output logic [WIDTH-1:0] oht
);

  // vec/res are always in "search from bit 0 upwards" order.
  logic [WIDTH-1:0] vec;
  logic [WIDTH-1:0] res;

  if (DIRECTION == DIR_MSB) begin : g_msb
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
      assign vec[i] = req[WIDTH-1-i] & msk[WIDTH-1-i];
      assign oht[i] = res[WIDTH-1-i];
    end
  end else begin : g_lsb
    assign vec = req & msk;
    assign oht = res;
  end

  if (IMPLEMENTATION == IMPL_LOOP) begin : g_loop
    always_comb begin
      logic found;
      res   = '0;
      found = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i] && !found) begin
          res[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end else if (IMPLEMENTATION == IMPL_VECTOR) begin : g_vector
    // Prefix-OR thermometer, then keep only its lowest edge.
    always_comb begin
      logic [WIDTH-1:0] thr;
      thr = vec;
      for (int s = 1; s < WIDTH; s = s * 2) begin
        thr = thr | (thr << s);
      end
      res = thr & ~(thr << 1);
    end
  end else if (IMPLEMENTATION == IMPL_ADDER) begin : g_adder
    assign res = vec & (~vec + WIDTH'(1));
  end else begin : g_bad_impl
    $fatal(1, "pry2oht_msk: IMPLEMENTATION must be 0, 1 or 2");
  end

endmodule

// File: rtl/arb_rr_base.sv
// Registered fixed/round-robin arbiter; grant appears 1 cycle after req is sampled.
// Grant is held until gnt_rdy; back-to-back grants while gnt_rdy stays high, lck pins the grant.
module arb_rr_base
  import arb_pkg::*;
#(
  parameter int          WIDTH          = 4,
  parameter logic [23:0] DIRECTION      = "LSB",
  parameter int          MODE           = 1,
  parameter int          IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [WIDTH-1:0]         req,
  input  logic                     lck,
  output logic [WIDTH-1:0]         gnt,
  output logic [$clog2(WIDTH)-1:0] gnt_idx,
  output logic                     gnt_vld,
  input  logic                     gnt_rdy
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] PTR_RST = (DIRECTION == DIR_MSB) ? '0 : IW'(WIDTH - 1);

  if (DIRECTION != DIR_LSB && DIRECTION != DIR_MSB) begin : g_bad_dir
    $fatal(1, "arb_rr_base: DIRECTION must be \"LSB\" or \"MSB\"");
  end
  if (MODE != MODE_FIXED && MODE != MODE_RR) begin : g_bad_mode
    $fatal(1, "arb_rr_base: MODE must be 0 or 1");
  end
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "arb_rr_base: WIDTH must be in 2..64");
  end

  arb_state_t       state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt, ptr_eff;
  logic [WIDTH-1:0] gnt_nxt;
  logic [IW-1:0]    gnt_idx_nxt;
  logic [WIDTH-1:0] msk;
  logic [WIDTH-1:0] oht_msk, oht_raw, win;
  logic             xfer;
  logic             arb;

  assign xfer    = gnt_vld & gnt_rdy;
  assign gnt_vld = (state != IDLE);

  // A transfer-cycle arbitration must already see ptr at the grant being retired.
  assign ptr_eff = gnt_vld ? gnt_idx : ptr;

  always_comb begin
    msk = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (DIRECTION == DIR_MSB) msk[i] = (IW'(i) < ptr_eff);
      else                      msk[i] = (IW'(i) > ptr_eff);
    end
  end

  pry2oht_msk #(
    .WIDTH          (WIDTH),
    .DIRECTION      (DIRECTION),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_pry_msk (
    .req (req),
    .msk (msk),
    .oht (oht_msk)
  );

  pry2oht_msk #(
    .WIDTH          (WIDTH),
    .DIRECTION      (DIRECTION),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_pry_raw (
    .req (req),
    .msk ({WIDTH{1'b1}}),
    .oht (oht_raw)
  );

  assign win = (MODE == MODE_RR && |oht_msk) ? oht_msk : oht_raw;

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    gnt_idx_nxt = gnt_idx;
    ptr_nxt     = ptr;
    arb         = 1'b0;
    case (state)
      IDLE: arb = 1'b1;
      GNT, LCK: begin
        if (xfer) begin
          if (state == GNT && MODE == MODE_RR) ptr_nxt = gnt_idx;
          if (lck) state_nxt = LCK;
          else     arb       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (arb) begin
      if (ena && |req) begin
        state_nxt   = GNT;
        gnt_nxt     = win;
        gnt_idx_nxt = IW'(onehot2bin(64'(win)));
      end else begin
        state_nxt   = IDLE;
        gnt_nxt     = '0;
        gnt_idx_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= PTR_RST;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= gnt_idx_nxt;
      ptr     <= ptr_nxt;
    end
  end

endmodule

// File: doc/arb_rr_base.md
# arb_rr_base

- Parametrised, registered request arbiter built around the priority-to-one-hot conversion.
- Adds what the combinational converter lacks: fixed or round-robin fairness, a pointer that persists across cycles, and a valid/ready grant handshake with grant hold and bus lock.
- Sits between WIDTH requesters and one shared resource, for example an interconnect port or a shared memory bank.

## Interface
- WIDTH, 4: number of requesters (2..64).
- DIRECTION, "LSB": tie-break order. "LSB" favours the rightmost request, "MSB" the leftmost. Any other value is a $fatal at elaboration.
- MODE, 1: 0 = fixed priority, 1 = round-robin. Any other value is a $fatal.
- IMPLEMENTATION, 0: converter style passed to the sub-module. 0 = loop, 1 = vector, 2 = adder.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  allows new arbitration. It does not affect a grant that is already pending.
- req  input  WIDTH  request vector.
- lck  input  1  lock; sampled on the transfer cycle.
- gnt  output  WIDTH  one-hot grant, registered.
- gnt_idx  output  $clog2(WIDTH)  binary index of gnt, registered.
- gnt_vld  output  1  grant valid.
- gnt_rdy  input  1  consumer accepts the grant.

## Operation
- Transfer: a cycle with gnt_vld & gnt_rdy.
- Arbitration: evaluated in state IDLE, or in the transfer cycle of state GNT when lck=0. Requires ena=1 and |req.
- Fixed mode (MODE=0): winner = priority-to-one-hot(req).
- Round-robin mode (MODE=1):
  - ptr holds the last granted index.
  - msk selects bits strictly after ptr in DIRECTION order: above ptr for "LSB", below ptr for "MSB".
  - winner = one-hot(req & msk) if that is nonzero, else one-hot(req).
- ptr updates to gnt_idx on every transfer in MODE=1. It is not updated while in LCK.
- States:
  - IDLE: gnt_vld=0. Goes to GNT when an arbitration produces a winner.
  - GNT: gnt_vld=1; gnt and gnt_idx are frozen until transfer. On transfer:
    - lck=1 → LCK, same grant kept.
    - lck=0 and a new winner exists → GNT, new grant loaded (back-to-back).
    - otherwise → IDLE.
  - LCK: gnt_vld=1; grant frozen and no arbitration. On transfer:
    - lck=1 → stay in LCK.
    - lck=0 → same exits as GNT.
- Requesters must hold req until granted. Dropping req while a grant is pending does not change gnt; the verification engineer adds an assertion for this protocol rule.
- Invariants:
  - gnt is zero or one-hot.
  - gnt_vld=1 implies gnt≠0.
  - gnt_idx always encodes gnt.

## Timing
- Reset values:
  - gnt=0, gnt_idx=0, gnt_vld=0, state IDLE.
  - ptr = WIDTH-1 for "LSB", 0 for "MSB", so the first round-robin search starts at the favoured end.
- Latency: req is sampled in IDLE and the grant appears 1 cycle later.
- Throughput: one grant per cycle when gnt_rdy is held at 1 (back-to-back through GNT→GNT).
- The arbitration in a transfer cycle uses ptr updated to the current grant. In round-robin mode, the requester just served wins again only if it is the sole requester.
- ena=0 during a transfer: the transfer completes, then the next state is IDLE (or LCK if lck=1).
- An asynchronous rst_n during GNT or LCK clears all outputs immediately. Nothing is retained.
- Wrap-around: when ptr is at the last position in DIRECTION order, msk=0 and the search falls back to unmasked req.

## Structure
- Package arb_pkg contains:
  - typedef arb_state_t {IDLE, GNT, LCK};
  - direction/mode constants;
  - function onehot2bin().
- Sub-module pry2oht_msk: combinational masked priority-to-one-hot conversion, parametrised by WIDTH, DIRECTION and IMPLEMENTATION.
  - Two instances: masked and unmasked.
  - The round-robin select, the state machine and all registers live in arb_rr_base.

## Test plan
All scenarios use WIDTH=4 unless stated.
- Reset: hold rst_n=0 → gnt=0, gnt_idx=0, gnt_vld=0. Release with req=0 → stays IDLE.
- Fixed mode, "LSB", req=4'b1010, gnt_rdy=1 → gnt=4'b0010 every cycle. Repeat with DIRECTION="MSB" → gnt=4'b1000.
- Round-robin, "LSB", req=4'b1111 held, gnt_rdy=1 → gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with no bubbles.
- Backpressure: grant 0100 pending with gnt_rdy=0 for 5 cycles while req changes to 0011 → gnt stays 0100. Raise gnt_rdy → next gnt=0001, because round-robin wraps.
- Lock: transfer of 0010 with lck=1, then 3 transfers with lck=1 while req=1111 → gnt stays 0010 throughout. First transfer with lck=0 → next gnt=0100.
- Mid-operation reset: assert rst_n=0 asynchronously in state LCK → outputs clear before the next clk edge. After release with req=1111 → first gnt=0001.
